// File: rtl/control_votacion_if.sv
// Bundle of session-control, vote-strobe and result signals between the voter
// front-ends, the session controller and the decision consumer.
interface control_votacion_if;
  logic       start;
  logic       va;
  logic       vb;
  logic       vc;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       v;
  logic [1:0] votes;
  logic [2:0] abst;
  logic       err;

  modport slave (
    input  start, va, vb, vc, a, b, c,
    output busy, done, v, votes, abst, err
  );

  modport master (
    output start, va, vb, vc, a, b, c,
    input  busy, done, v, votes, abst, err
  );
endinterface

// File: rtl/control_votacion.sv
// Voting session controller: opens on start, collects one vote per voter until
// all have voted or the timeout expires, then publishes majority, yes count and abstentions.
module control_votacion #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input logic                clk,
  input logic                reset,
  control_votacion_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EVAL    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    reg_q, reg_d;
  logic [2:0]    val_q, val_d;
  logic          err_q, err_d;
  logic          v_q, v_d;
  logic [1:0]    votes_q, votes_d;
  logic [2:0]    abst_q, abst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [2:0]    stb_s, vin_s, new_s, mask_s, yes_s;

  function automatic logic [1:0] popcount3(input logic [2:0] x);
    return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
  endfunction

  function automatic logic majority3(input logic [2:0] x);
    return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
  endfunction

  assign stb_s  = {bus.vc, bus.vb, bus.va};
  assign vin_s  = {bus.c, bus.b, bus.a};
  assign new_s  = stb_s & ~reg_q;
  assign mask_s = reg_q | stb_s;
  // Abstentions count as no: only registered voters can contribute a yes.
  assign yes_s  = reg_q & val_q;

  // Next-state and next-output logic of the session FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    val_d   = val_q;
    err_d   = err_q;
    v_d     = v_q;
    votes_d = votes_q;
    abst_d  = abst_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          reg_d   = 3'b000;
          val_d   = 3'b000;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        reg_d = mask_s;
        val_d = (val_q & ~new_s) | (vin_s & new_s);
        if (|(stb_s & reg_q)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if ((mask_s == 3'b111) || (cnt_q == LAST_CNT)) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EVAL: begin
        votes_d = popcount3(yes_s);
        v_d     = majority3(yes_s);
        abst_d  = ~reg_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      reg_q   <= 3'b000;
      val_q   <= 3'b000;
      err_q   <= 1'b0;
      v_q     <= 1'b0;
      votes_q <= 2'b00;
      abst_q  <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      err_q   <= err_d;
      v_q     <= v_d;
      votes_q <= votes_d;
      abst_q  <= abst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.v     = v_q;
  assign bus.votes = votes_q;
  assign bus.abst  = abst_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_control_votacion.sv
// Bench for control_votacion: two instances (TIMEOUT 15 and 4) share one stimulus
// stream; each is checked every cycle against a session-level reference model.
module tb_control_votacion;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_votacion_if ifa();
  control_votacion_if ifb();

  assign ifb.start = ifa.start;
  assign ifb.va    = ifa.va;
  assign ifb.vb    = ifa.vb;
  assign ifb.vc    = ifa.vc;
  assign ifb.a     = ifa.a;
  assign ifb.b     = ifa.b;
  assign ifb.c     = ifa.c;

  control_votacion #(.TIMEOUT(15), .CW(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  control_votacion #(.TIMEOUT(4),  .CW(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int total = 0;
  int bad   = 0;

  // Session schedule: strobes/values per COLLECT offset, stray starts per cycle.
  logic [2:0] sched_s [32];
  logic [2:0] sched_v [32];
  logic       stray   [32];

  int         tmo     [2] = '{15, 4};
  int         close_m [2];
  int         rep_m   [2];
  logic [1:0] nvotes  [2];
  logic [1:0] pvotes  [2];
  logic [2:0] nabst   [2];
  logic [2:0] pabst   [2];
  logic       nv      [2];
  logic       pv      [2];
  logic       perr    [2];

  task automatic chk(input string tag, input int i, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst%0d t=%0t observed=%0h expected=%0h", tag, i, $time, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] s, input logic [2:0] val);
    ifa.start = st;
    {ifa.vc, ifa.vb, ifa.va} = s;
    {ifa.c, ifa.b, ifa.a}    = val;
  endtask

  task automatic clr_sched;
    for (int k = 0; k < 32; k++) begin
      sched_s[k] = 3'b000;
      sched_v[k] = 3'b000;
      stray[k]   = 1'b0;
    end
  endtask

  // Reference: walk the schedule, first strobe per voter counts, repeats flag err.
  task automatic model(input int i);
    logic [2:0] seen;
    logic [2:0] yes;
    seen = 3'b000;
    yes  = 3'b000;
    close_m[i] = tmo[i] - 1;
    rep_m[i]   = -1;
    for (int k = 0; k < tmo[i]; k++) begin
      for (int x = 0; x < 3; x++) begin
        if (sched_s[k][x]) begin
          if (seen[x]) begin
            if (rep_m[i] < 0) rep_m[i] = k;
          end else begin
            seen[x] = 1'b1;
            yes[x]  = sched_v[k][x];
          end
        end
      end
      if (seen == 3'b111) begin
        close_m[i] = k;
        break;
      end
    end
    yes = yes & seen;
    nvotes[i] = 2'(int'(yes[0]) + int'(yes[1]) + int'(yes[2]));
    nv[i]     = (yes[0] & yes[1]) | (yes[0] & yes[2]) | (yes[1] & yes[2]);
    nabst[i]  = ~seen;
  endtask

  // Cycle j counts clock edges since the start-acceptance edge.
  task automatic check_cycle(input int i, input int j, input logic busy, input logic done,
                             input logic v, input logic [1:0] votes, input logic [2:0] abst,
                             input logic err);
    int   dj;
    logic after;
    dj    = close_m[i] + 3;
    after = (j >= dj);
    chk("busy",  i, 4'(busy),  4'(j <= dj));
    chk("done",  i, 4'(done),  4'(j == dj));
    chk("err",   i, 4'(err),   4'((rep_m[i] >= 0) && (j >= rep_m[i] + 2)));
    chk("v",     i, 4'(v),     4'(after ? nv[i] : pv[i]));
    chk("votes", i, 4'(votes), 4'(after ? nvotes[i] : pvotes[i]));
    chk("abst",  i, 4'(abst),  4'(after ? nabst[i] : pabst[i]));
  endtask

  task automatic run_session;
    int dmin;
    int dmax;
    model(0);
    model(1);
    dmin = (close_m[0] < close_m[1] ? close_m[0] : close_m[1]) + 3;
    dmax = (close_m[0] > close_m[1] ? close_m[0] : close_m[1]) + 3;
    drive(1'b1, 3'b000, 3'b000);
    tick;
    for (int j = 1; j <= dmax + 1; j++) begin
      check_cycle(0, j, ifa.busy, ifa.done, ifa.v, ifa.votes, ifa.abst, ifa.err);
      check_cycle(1, j, ifb.busy, ifb.done, ifb.v, ifb.votes, ifb.abst, ifb.err);
      if (j <= dmax) begin
        drive(stray[j] && (j <= dmin), sched_s[j-1], sched_v[j-1]);
        tick;
      end else begin
        drive(1'b0, 3'b000, 3'b000);
      end
    end
    for (int i = 0; i < 2; i++) begin
      pv[i]     = nv[i];
      pvotes[i] = nvotes[i];
      pabst[i]  = nabst[i];
      perr[i]   = (rep_m[i] >= 0);
    end
  endtask

  task automatic check_idle(input int i, input logic busy, input logic done, input logic v,
                            input logic [1:0] votes, input logic [2:0] abst, input logic err);
    chk("idle_busy",  i, 4'(busy),  4'b0000);
    chk("idle_done",  i, 4'(done),  4'b0000);
    chk("idle_err",   i, 4'(err),   4'(perr[i]));
    chk("idle_v",     i, 4'(v),     4'(pv[i]));
    chk("idle_votes", i, 4'(votes), 4'(pvotes[i]));
    chk("idle_abst",  i, 4'(abst),  4'(pabst[i]));
  endtask

  task automatic idle_noise(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      tick;
      check_idle(0, ifa.busy, ifa.done, ifa.v, ifa.votes, ifa.abst, ifa.err);
      check_idle(1, ifb.busy, ifb.done, ifb.v, ifb.votes, ifb.abst, ifb.err);
    end
    drive(1'b0, 3'b000, 3'b000);
  endtask

  task automatic clear_prev;
    for (int i = 0; i < 2; i++) begin
      pv[i]     = 1'b0;
      pvotes[i] = 2'b00;
      pabst[i]  = 3'b000;
      perr[i]   = 1'b0;
    end
  endtask

  initial begin
    int code [3];
    reset = 1'b1;
    drive(1'b0, 3'b000, 3'b000);
    clear_prev();
    tick;
    tick;
    check_idle(0, ifa.busy, ifa.done, ifa.v, ifa.votes, ifa.abst, ifa.err);
    check_idle(1, ifb.busy, ifb.done, ifb.v, ifb.votes, ifb.abst, ifb.err);
    reset = 1'b0;
    tick;

    // All three voters in the first COLLECT cycle.
    clr_sched();
    sched_s[0] = 3'b111; sched_v[0] = 3'b011;
    run_session();

    // a yes, b no two cycles later, c abstains: timeout path.
    clr_sched();
    sched_s[0] = 3'b001; sched_v[0] = 3'b001;
    sched_s[2] = 3'b010; sched_v[2] = 3'b000;
    run_session();

    // Repeated a strobe sets err; next session clears it.
    clr_sched();
    sched_s[0] = 3'b001; sched_v[0] = 3'b001;
    sched_s[1] = 3'b001; sched_v[1] = 3'b000;
    sched_s[2] = 3'b010; sched_v[2] = 3'b010;
    sched_s[3] = 3'b100; sched_v[3] = 3'b100;
    run_session();

    // Only c, in the 4th COLLECT cycle (last cycle for the TIMEOUT=4 instance).
    clr_sched();
    sched_s[3] = 3'b100; sched_v[3] = 3'b100;
    run_session();

    idle_noise(4);

    // Reset mid-session wins over simultaneous start and strobes.
    drive(1'b1, 3'b000, 3'b000);
    tick;
    chk("rst_pre_busy", 0, 4'(ifa.busy), 4'b0001);
    drive(1'b0, 3'b001, 3'b001);
    tick;
    chk("rst_pre_busy", 1, 4'(ifb.busy), 4'b0001);
    reset = 1'b1;
    drive(1'b1, 3'b111, 3'b111);
    tick;
    clear_prev();
    check_idle(0, ifa.busy, ifa.done, ifa.v, ifa.votes, ifa.abst, ifa.err);
    check_idle(1, ifb.busy, ifb.done, ifb.v, ifb.votes, ifb.abst, ifb.err);
    reset = 1'b0;
    drive(1'b0, 3'b000, 3'b000);
    tick;
    check_idle(0, ifa.busy, ifa.done, ifa.v, ifa.votes, ifa.abst, ifa.err);
    check_idle(1, ifb.busy, ifb.done, ifb.v, ifb.votes, ifb.abst, ifb.err);

    // Session with no votes at all.
    clr_sched();
    run_session();

    // All 27 yes/no/abstain combinations, votes spread over the first three cycles.
    for (int ca = 0; ca < 3; ca++) begin
      for (int cb = 0; cb < 3; cb++) begin
        for (int cc = 0; cc < 3; cc++) begin
          code[0] = ca; code[1] = cb; code[2] = cc;
          clr_sched();
          for (int x = 0; x < 3; x++) begin
            if (code[x] != 0) begin
              int k;
              k = $urandom_range(0, 2);
              sched_s[k][x] = 1'b1;
              sched_v[k][x] = (code[x] == 1);
            end
          end
          for (int j = 1; j < 20; j++) stray[j] = ($urandom_range(0, 3) == 0);
          run_session();
        end
      end
    end

    // Random sessions with sparse strobes, repeats and stray starts.
    for (int s = 0; s < 25; s++) begin
      clr_sched();
      for (int k = 0; k < 20; k++) begin
        for (int x = 0; x < 3; x++) begin
          sched_s[k][x] = ($urandom_range(0, 4) == 0);
          sched_v[k][x] = 1'($urandom_range(0, 1));
        end
        stray[k] = ($urandom_range(0, 3) == 0);
      end
      run_session();
      if ((s % 5) == 0) idle_noise(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_votacion.md
# control_votacion

Sequential session controller for the three-input majority voter. It opens a voting session on `start` and collects at most one vote per voter (a, b, c) through per-voter strobes. The session closes when all three voters have voted or a cycle timeout expires; the block then evaluates the majority and reports the result, the yes count and the abstention mask. It sits between the voter front-ends and the downstream logic that consumes the decision.

## Interface
- `TIMEOUT`, 15: maximum number of cycles spent in COLLECT; legal range 1..2^CW-1.
- `CW`, 4: width of the internal timeout counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  opens a session; accepted only in IDLE.
- `va`, `vb`, `vc`  in  1 each  one-cycle vote strobes for voters a, b, c.
- `a`, `b`, `c`  in  1 each  vote value (1 = yes), sampled when the matching strobe is high.
- `busy`  out  1  high in COLLECT, EVAL and DONE.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle.
- `v`  out  1  majority decision: 1 if at least two yes votes.
- `votes`  out  2  number of yes votes received (0..3).
- `abst`  out  3  abstention mask {c,b,a}; bit = 1 means that voter did not vote.
- `err`  out  1  sticky: a voter strobed again after its vote was registered in this session.

## Operation
- States: IDLE, COLLECT, EVAL, DONE.
- IDLE: `start` = 1 → COLLECT. In the same edge, clear the counter, the registered-vote mask, the stored vote values and `err`. `v`, `votes` and `abst` keep the previous session's values.
- COLLECT: each cycle, for each voter x with strobe high:
  - If not yet registered: set registered[x] and store the value.
  - If already registered: ignore the value and set `err`.
  - Simultaneous strobes are all accepted in the same cycle.
- Leave COLLECT for EVAL at the end of the cycle in which the mask becomes 111, counting strobes captured in that same cycle. Also leave it at the end of the cycle in which the counter equals TIMEOUT-1; strobes in that cycle are still accepted. Otherwise increment the counter.
- EVAL, one cycle:
  - `votes` = number of registered voters whose stored value is 1.
  - `v` = (`votes` ≥ 2).
  - `abst` = ~registered mask.
  - Abstentions count as no.
  - Go to DONE.
- DONE, one cycle: `done` = 1, then go to IDLE.
- Strobes in IDLE, EVAL and DONE are ignored and do not set `err`.
- `start` outside IDLE is ignored.
- Arithmetic: `votes` is a 2-bit sum of three 1-bit terms and cannot overflow. The counter never exceeds TIMEOUT-1.

## Timing
- Reset, at any time including mid-session:
  - State goes to IDLE on the next edge.
  - `busy`, `done`, `v` = 0; `votes` = 00; `abst` = 000; `err` = 0; counter and mask are cleared.
  - Reset has priority over `start` and the strobes.
- `start` accepted at edge N: `busy` = 1 from cycle N+1.
- Last vote captured at edge M: EVAL in cycle M+1, `done` = 1 in cycle M+2, IDLE (`busy` = 0) in cycle M+3.
- Timeout path: `done` rises exactly TIMEOUT+2 cycles after the start-acceptance edge.
- Minimum session, all three strobes in the first COLLECT cycle: `done` rises 3 cycles after the start edge.
- A new `start` is accepted in the first IDLE cycle after DONE.
- `v`, `votes` and `abst` are registered. They update in the EVAL→DONE edge and are stable during `done` and until the next EVAL.
- `err` is registered, may rise during COLLECT, and holds until the next accepted `start` or reset.

## Test plan
- Reset, then start; in cycle 1 strobe va with a=1, vb with b=1 and vc with c=0 together → `done` 3 cycles after start, `v`=1, `votes`=10, `abst`=000, `err`=0.
- Start; strobe va with a=1, then vb with b=0 two cycles later; no vc; TIMEOUT=15 → `done` at start+17, `v`=0, `votes`=01, `abst`=100.
- Start; va with a=1, then va again with a=0, then vb with b=1, vc with c=1 → second va ignored, `err`=1, `votes`=11, `v`=1, `abst`=000; next start clears `err`.
- TIMEOUT=4; strobe vc with c=1 in the 4th COLLECT cycle only → vote accepted, `votes`=01, `abst`=011, `done` at start+6.
- Assert reset during COLLECT after va with a=1 → next cycle all outputs 0, IDLE; a new session with no votes and TIMEOUT=15 gives `abst`=111, `votes`=00, `v`=0.
- Pulse `start` and strobes while busy, and strobes in IDLE → no effect on state, mask or `err`; exhaustively check all 27 vote/abstain combinations against majority(a·b + a·c + b·c), with abstentions treated as 0.
